// File: rtl/lift_scheduler.sv
// lift_scheduler: collective (SCAN) dispatcher for a single lift car.
// Latches cab and hall calls into pending registers, moves the car one floor
// every MOVE_CYC cycles, opens the door for DOOR_CYC cycles at served floors
// and reverses when no work remains ahead.
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   cab_req  cab buttons, bit i-1 = floor i
//   hall_up  hall up-calls (top floor bit ignored)
//   hall_dn  hall down-calls (floor 1 bit ignored)
//   floor_o  current floor, 1..FLOORS
//   dir_o    00 idle, 01 up, 10 down
//   door_o   door open
//   busy_o   FSM not idle
//   pend_o   per-floor OR of pending cab/up/dn calls
//
// state  | meaning
// IDLE   | car parked, waits one cycle after requests appear, then dispatches
// MOVE   | travelling; floor steps on move-counter terminal count
// DOOR   | door open for DOOR_CYC cycles; calls at this floor are absorbed
module lift_scheduler #(
   parameter int FLOORS   = 7,
   parameter int MOVE_CYC = 4,
   parameter int DOOR_CYC = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FLOORS-1:0] cab_req,
   input  logic [FLOORS-1:0] hall_up,
   input  logic [FLOORS-1:0] hall_dn,
   output logic [2:0]        floor_o,
   output logic [1:0]        dir_o,
   output logic              door_o,
   output logic              busy_o,
   output logic [FLOORS-1:0] pend_o
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MOVE = 2'd1;
   localparam logic [1:0] S_DOOR = 2'd2;

   localparam logic [1:0] DIR_NONE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DN   = 2'b10;

   localparam int MCW = (MOVE_CYC > 1) ? $clog2(MOVE_CYC) : 1;
   localparam int DCW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
   localparam logic [MCW-1:0] MOVE_TC = MCW'(MOVE_CYC - 1);
   localparam logic [DCW-1:0] DOOR_TC = DCW'(DOOR_CYC - 1);
   localparam logic [2:0]     TOP     = 3'(FLOORS);

   // Top floor has no up-call, floor 1 has no down-call.
   localparam logic [FLOORS-1:0] UP_OK = {1'b0, {(FLOORS-1){1'b1}}};
   localparam logic [FLOORS-1:0] DN_OK = {{(FLOORS-1){1'b1}}, 1'b0};

   logic [1:0]        state_q, state_d;
   logic [1:0]        dir_q, dir_d;
   logic [2:0]        floor_q, floor_d;
   logic [MCW-1:0]    mcnt_q, mcnt_d;
   logic [DCW-1:0]    dcnt_q, dcnt_d;
   logic              arrived_q, arrived_d;
   logic              arm_q;
   logic [FLOORS-1:0] cab_q, up_q, dn_q;
   logic [FLOORS-1:0] cab_clr, up_clr, dn_clr;

   logic [FLOORS-1:0] pend, f_oh, above_m, below_m, up_in, dn_in;
   logic              above, below, here, cab_f, up_f, dn_f;
   logic              beyond, behind, same_f, opp_f, stop_here, absorb;

   always_comb begin
      f_oh    = '0;
      above_m = '0;
      below_m = '0;
      for (int i = 0; i < FLOORS; i++) begin
         f_oh[i]    = (floor_q == 3'(i + 1));
         above_m[i] = (3'(i + 1) > floor_q);
         below_m[i] = (3'(i + 1) < floor_q);
      end
   end

   assign pend   = cab_q | up_q | dn_q;
   assign up_in  = hall_up & UP_OK;
   assign dn_in  = hall_dn & DN_OK;
   assign above  = |(pend & above_m);
   assign below  = |(pend & below_m);
   assign cab_f  = |(cab_q & f_oh);
   assign up_f   = |(up_q & f_oh);
   assign dn_f   = |(dn_q & f_oh);
   assign here   = cab_f | up_f | dn_f;

   assign beyond = (dir_q == DIR_UP) ? above : (dir_q == DIR_DN) ? below : 1'b0;
   assign behind = (dir_q == DIR_UP) ? below : (dir_q == DIR_DN) ? above : 1'b0;
   assign same_f = (dir_q == DIR_UP) ? up_f  : (dir_q == DIR_DN) ? dn_f  : 1'b0;
   assign opp_f  = (dir_q == DIR_UP) ? dn_f  : (dir_q == DIR_DN) ? up_f  : 1'b0;
   assign stop_here = cab_f | same_f | (~beyond & opp_f);

   // With no direction (door opened from idle) both hall calls count as "same".
   assign absorb = |(cab_req & f_oh)
                 | ((dir_q != DIR_DN) & |(up_in & f_oh))
                 | ((dir_q != DIR_UP) & |(dn_in & f_oh));

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      floor_d   = floor_q;
      mcnt_d    = mcnt_q;
      dcnt_d    = dcnt_q;
      arrived_d = 1'b0;
      cab_clr   = '0;
      up_clr    = '0;
      dn_clr    = '0;
      case (state_q)
         S_IDLE: begin
            if (arm_q) begin
               if (here) begin
                  state_d = S_DOOR;
                  dcnt_d  = '0;
                  cab_clr = f_oh;
                  up_clr  = f_oh;
                  dn_clr  = f_oh;
               end else if (above) begin
                  dir_d   = DIR_UP;
                  state_d = S_MOVE;
                  mcnt_d  = '0;
               end else if (below) begin
                  dir_d   = DIR_DN;
                  state_d = S_MOVE;
                  mcnt_d  = '0;
               end
            end
         end
         S_MOVE: begin
            if (arrived_q && stop_here) begin
               state_d = S_DOOR;
               dcnt_d  = '0;
               mcnt_d  = '0;
               cab_clr = f_oh;
               if (dir_q == DIR_UP || !beyond) up_clr = f_oh;
               if (dir_q == DIR_DN || !beyond) dn_clr = f_oh;
            end else if (mcnt_q == MOVE_TC) begin
               mcnt_d    = '0;
               arrived_d = 1'b1;
               if (dir_q == DIR_UP && floor_q < TOP)
                  floor_d = floor_q + 3'd1;
               else if (dir_q == DIR_DN && floor_q > 3'd1)
                  floor_d = floor_q - 3'd1;
            end else begin
               mcnt_d = mcnt_q + MCW'(1);
            end
         end
         S_DOOR: begin
            // Calls at this floor that the open door serves are never latched.
            cab_clr = f_oh;
            if (dir_q != DIR_DN) up_clr = f_oh;
            if (dir_q != DIR_UP) dn_clr = f_oh;
            if (absorb) begin
               dcnt_d = '0;
            end else if (dcnt_q == DOOR_TC) begin
               mcnt_d = '0;
               if (dir_q == DIR_NONE) begin
                  if (above) begin
                     dir_d   = DIR_UP;
                     state_d = S_MOVE;
                  end else if (below) begin
                     dir_d   = DIR_DN;
                     state_d = S_MOVE;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else if (beyond) begin
                  state_d = S_MOVE;
               end else if (behind) begin
                  dir_d   = ~dir_q;
                  state_d = S_MOVE;
               end else if (opp_f) begin
                  // Serve the waiting opposite call without leaving the floor.
                  dir_d  = ~dir_q;
                  dcnt_d = '0;
                  if (dir_q == DIR_UP) dn_clr = f_oh;
                  else                 up_clr = f_oh;
               end else begin
                  dir_d   = DIR_NONE;
                  state_d = S_IDLE;
               end
            end else begin
               dcnt_d = dcnt_q + DCW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            dir_d   = DIR_NONE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         dir_q     <= DIR_NONE;
         floor_q   <= 3'd1;
         mcnt_q    <= '0;
         dcnt_q    <= '0;
         arrived_q <= 1'b0;
         arm_q     <= 1'b0;
         cab_q     <= '0;
         up_q      <= '0;
         dn_q      <= '0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         floor_q   <= floor_d;
         mcnt_q    <= mcnt_d;
         dcnt_q    <= dcnt_d;
         arrived_q <= arrived_d;
         // Idle dispatch waits one cycle after requests become visible.
         arm_q     <= (state_q == S_IDLE) && (|pend);
         cab_q     <= (cab_q | cab_req) & ~cab_clr;
         up_q      <= (up_q | up_in) & ~up_clr;
         dn_q      <= (dn_q | dn_in) & ~dn_clr;
      end
   end

   assign floor_o = floor_q;
   assign dir_o   = dir_q;
   assign door_o  = (state_q == S_DOOR);
   assign busy_o  = (state_q != S_IDLE);
   assign pend_o  = pend;

endmodule

// File: tb/tb_lift_scheduler.sv
// Bench for lift_scheduler: directed scenarios with literal expectations plus
// randomized calls checked every cycle against a floor-level behavioural model.
module tb_lift_scheduler;
   localparam int F        = 7;
   localparam int MOVE_CYC = 4;
   localparam int DOOR_CYC = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [F-1:0] cab_req, hall_up, hall_dn;
   logic [2:0]   floor_o;
   logic [1:0]   dir_o;
   logic         door_o, busy_o;
   logic [F-1:0] pend_o;

   int n_cmp = 0;
   int n_bad = 0;

   lift_scheduler #(.FLOORS(F), .MOVE_CYC(MOVE_CYC), .DOOR_CYC(DOOR_CYC)) dut (
      .clk(clk), .rst(rst), .cab_req(cab_req), .hall_up(hall_up), .hall_dn(hall_dn),
      .floor_o(floor_o), .dir_o(dir_o), .door_o(door_o), .busy_o(busy_o), .pend_o(pend_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (floor numbers 1..F) ----------------
   // mode: 0 parked, 1 travelling, 2 door open; dir: +1 up, -1 down, 0 none
   bit m_valid = 0;
   int m_floor, m_dir, m_mode, m_travel, m_door_left;
   bit m_arrived, m_wait;
   bit m_c[1:F], m_u[1:F], m_d[1:F];

   function automatic bit m_any(int lo, int hi);
      for (int i = lo; i <= hi; i++)
         if (i >= 1 && i <= F && (m_c[i] || m_u[i] || m_d[i])) return 1;
      return 0;
   endfunction

   function automatic bit m_ahead(int f, int d);
      if (d > 0) return m_any(f + 1, F);
      if (d < 0) return m_any(1, f - 1);
      return 0;
   endfunction

   function automatic bit m_hall(int f, int d);
      if (d > 0) return m_u[f];
      if (d < 0) return m_d[f];
      return 0;
   endfunction

   function automatic logic [F-1:0] m_pend();
      logic [F-1:0] p;
      for (int i = 1; i <= F; i++) p[i-1] = m_c[i] | m_u[i] | m_d[i];
      return p;
   endfunction

   function automatic bit up_at(int i);
      return (i < F) && hall_up[i-1];
   endfunction

   function automatic bit dn_at(int i);
      return (i > 1) && hall_dn[i-1];
   endfunction

   task automatic m_start_move();
      m_mode = 1; m_travel = MOVE_CYC; m_arrived = 0;
   endtask

   task automatic model_step();
      int  f, d, old_mode;
      bit  clr_c, clr_u, clr_d, any_p;
      if (rst) begin
         m_valid = 1; m_floor = 1; m_dir = 0; m_mode = 0; m_travel = 0;
         m_door_left = 0; m_arrived = 0; m_wait = 0;
         for (int i = 1; i <= F; i++) begin m_c[i] = 0; m_u[i] = 0; m_d[i] = 0; end
         return;
      end
      if (!m_valid) return;
      f = m_floor; d = m_dir; old_mode = m_mode;
      clr_c = 0; clr_u = 0; clr_d = 0;
      any_p = m_any(1, F);
      case (m_mode)
         0: if (m_wait) begin
            if (m_c[f] || m_u[f] || m_d[f]) begin
               m_mode = 2; m_door_left = DOOR_CYC; clr_c = 1; clr_u = 1; clr_d = 1;
            end else if (m_ahead(f, 1)) begin
               m_dir = 1; m_start_move();
            end else if (m_ahead(f, -1)) begin
               m_dir = -1; m_start_move();
            end
         end
         1: begin
            if (m_arrived && (m_c[f] || m_hall(f, d) || (!m_ahead(f, d) && m_hall(f, -d)))) begin
               m_mode = 2; m_door_left = DOOR_CYC; m_arrived = 0; clr_c = 1;
               if (d > 0 || !m_ahead(f, d)) clr_u = 1;
               if (d < 0 || !m_ahead(f, d)) clr_d = 1;
            end else if (m_travel == 1) begin
               m_floor = f + d; m_travel = MOVE_CYC; m_arrived = 1;
            end else begin
               m_travel--; m_arrived = 0;
            end
         end
         default: begin
            clr_c = 1;
            if (d >= 0) clr_u = 1;
            if (d <= 0) clr_d = 1;
            if (cab_req[f-1] || (d >= 0 && up_at(f)) || (d <= 0 && dn_at(f))) begin
               m_door_left = DOOR_CYC;
            end else if (m_door_left == 1) begin
               if (d == 0) begin
                  if (m_ahead(f, 1))       begin m_dir = 1;  m_start_move(); end
                  else if (m_ahead(f, -1)) begin m_dir = -1; m_start_move(); end
                  else m_mode = 0;
               end else if (m_ahead(f, d)) begin
                  m_start_move();
               end else if (m_ahead(f, -d)) begin
                  m_dir = -d; m_start_move();
               end else if (m_hall(f, -d)) begin
                  m_dir = -d; m_door_left = DOOR_CYC;
                  if (d > 0) clr_d = 1; else clr_u = 1;
               end else begin
                  m_dir = 0; m_mode = 0;
               end
            end else begin
               m_door_left--;
            end
         end
      endcase
      m_wait = (old_mode == 0) && any_p;
      for (int i = 1; i <= F; i++) begin
         m_c[i] = (m_c[i] | cab_req[i-1]) && !(i == f && clr_c);
         m_u[i] = (m_u[i] | up_at(i))     && !(i == f && clr_u);
         m_d[i] = (m_d[i] | dn_at(i))     && !(i == f && clr_d);
      end
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      if (m_valid) begin
         chk("floor", int'(floor_o), m_floor);
         chk("dir", int'(dir_o), (m_dir > 0) ? 1 : (m_dir < 0) ? 2 : 0);
         chk("door", int'(door_o), int'(m_mode == 2));
         chk("busy", int'(busy_o), int'(m_mode != 0));
         chk("pend", int'(pend_o), int'(m_pend()));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [F-1:0] c, input logic [F-1:0] u, input logic [F-1:0] dn);
      cab_req = c; hall_up = u; hall_dn = dn;
      tick();
      cab_req = '0; hall_up = '0; hall_dn = '0;
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int stops_f[$];
      int stops_d[$];
      int exp_f[3];
      int exp_d[3];
      bit prev_door;
      exp_f = '{4, 6, 3};
      exp_d = '{1, 1, 2};
      rst = 1'b1; cab_req = '0; hall_up = '0; hall_dn = '0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_floor", int'(floor_o), 1);
      chk("rst_dir", int'(dir_o), 0);
      chk("rst_door", int'(door_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_pend", int'(pend_o), 0);
      tick();

      // Here-call at floor 1 with a repeat press while the door is open.
      pulse(7'h00, 7'h01, 7'h00);
      chk("here_door_n0", int'(door_o), 0);
      tick();
      chk("here_door_n1", int'(door_o), 0);
      tick();
      chk("here_door_n2", int'(door_o), 1);
      pulse(7'h00, 7'h01, 7'h00);
      chk("here_pend_absorbed", int'(pend_o), 0);
      tick(); tick();
      chk("here_door_extended", int'(door_o), 1);
      tick();
      chk("here_door_closed", int'(door_o), 0);
      chk("here_floor", int'(floor_o), 1);

      // Calls that do not exist on the panel.
      pulse(7'h00, 7'h40, 7'h01);
      tick(); tick();
      chk("ign_pend", int'(pend_o), 0);
      chk("ign_busy", int'(busy_o), 0);

      // Single trip 1 -> 4.
      pulse(7'h08, 7'h00, 7'h00);
      chk("trip_pend", int'(pend_o), 8);
      tick();
      chk("trip_busy_n1", int'(busy_o), 0);
      tick();
      chk("trip_dir", int'(dir_o), 1);
      tick(); tick(); tick();
      chk("trip_floor_n5", int'(floor_o), 1);
      tick();
      chk("trip_floor_n6", int'(floor_o), 2);
      repeat (4) tick();
      chk("trip_floor_n10", int'(floor_o), 3);
      repeat (4) tick();
      chk("trip_floor_n14", int'(floor_o), 4);
      chk("trip_door_n14", int'(door_o), 0);
      tick();
      chk("trip_door_n15", int'(door_o), 1);
      tick(); tick();
      chk("trip_door_n17", int'(door_o), 1);
      tick();
      chk("trip_door_n18", int'(door_o), 0);
      chk("trip_dir_idle", int'(dir_o), 0);
      chk("trip_pend_clear", int'(pend_o), 0);

      // Collective sweep: cab 6, hall down 3, hall up 4.
      reset_pulse();
      pulse(7'h20, 7'h08, 7'h04);
      prev_door = 0;
      for (int k = 0; k < 300; k++) begin
         if (door_o && !prev_door) begin
            stops_f.push_back(int'(floor_o));
            stops_d.push_back(int'(dir_o));
         end
         prev_door = door_o;
         if (!busy_o && stops_f.size() > 0) break;
         tick();
      end
      chk("coll_nstops", stops_f.size(), 3);
      for (int k = 0; k < 3; k++) begin
         chk("coll_stop_floor", (k < stops_f.size()) ? stops_f[k] : 0, exp_f[k]);
         chk("coll_stop_dir", (k < stops_d.size()) ? stops_d[k] : 0, exp_d[k]);
      end
      chk("coll_final_floor", int'(floor_o), 3);
      chk("coll_final_busy", int'(busy_o), 0);

      // Reset while travelling between floors 2 and 3 towards floor 5.
      reset_pulse();
      pulse(7'h10, 7'h00, 7'h00);
      for (int k = 0; k < 100 && floor_o != 3'd2; k++) tick();
      chk("mid_reach_floor2", int'(floor_o), 2);
      tick(); tick();
      chk("mid_moving", int'(busy_o), 1);
      reset_pulse();
      chk("mid_floor", int'(floor_o), 1);
      chk("mid_dir", int'(dir_o), 0);
      chk("mid_pend", int'(pend_o), 0);
      chk("mid_busy", int'(busy_o), 0);
      repeat (20) tick();
      chk("mid_still_floor", int'(floor_o), 1);
      chk("mid_still_busy", int'(busy_o), 0);

      // Randomized calls with occasional reset.
      for (int k = 0; k < 4000; k++) begin
         cab_req = '0; hall_up = '0; hall_dn = '0;
         if ($urandom_range(0, 4) == 0) begin
            case ($urandom_range(0, 2))
               0:       cab_req[$urandom_range(0, F-1)] = 1'b1;
               1:       hall_up[$urandom_range(0, F-1)] = 1'b1;
               default: hall_dn[$urandom_range(0, F-1)] = 1'b1;
            endcase
         end
         rst = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 1'b0; cab_req = '0; hall_up = '0; hall_dn = '0;
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
